// File: rtl/fir_serial_mac_pkg.sv
// Shared filter package: widths, test coefficients, FSM state type and
// saturation helpers used by the serial MAC FIR.
package fir_serial_mac_pkg;

  localparam int unsigned DATABITS      = 16;
  localparam int unsigned ACCBITS       = 36;
  localparam int unsigned COEF_BITS_DEF = 16;
  localparam int unsigned MULBITS       = DATABITS + COEF_BITS_DEF;
  localparam int unsigned CLK_PERIOD    = 10;

  localparam logic [COEF_BITS_DEF-1:0] TEST_COEF_MAX  = 16'h7FFF;
  localparam logic [COEF_BITS_DEF-1:0] TEST_COEF_NEG1 = 16'hFFFF;
  localparam logic [DATABITS-1:0]      TEST_X_MAX     = 16'h7FFF;
  localparam logic [DATABITS-1:0]      TEST_X_MIN     = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Sum of two in-range accumulator values overflows iff the top two bits differ.
  function automatic logic acc_ovf(input logic [ACCBITS:0] v);
    return v[ACCBITS] ^ v[ACCBITS-1];
  endfunction

  function automatic logic [ACCBITS-1:0] sat_acc(input logic [ACCBITS:0] v);
    if (acc_ovf(v))
      return v[ACCBITS] ? {1'b1, {(ACCBITS-1){1'b0}}} : {1'b0, {(ACCBITS-1){1'b1}}};
    return v[ACCBITS-1:0];
  endfunction

  // Fits in DATABITS iff every bit from the output sign bit upward agrees.
  function automatic logic out_ovf(input logic [ACCBITS:0] v);
    logic [ACCBITS-DATABITS+1:0] hi;
    hi = v[ACCBITS:DATABITS-1];
    return !((&hi) || !(|hi));
  endfunction

  function automatic logic [DATABITS-1:0] sat_out(input logic [ACCBITS:0] v);
    if (out_ovf(v))
      return v[ACCBITS] ? {1'b1, {(DATABITS-1){1'b0}}} : {1'b0, {(DATABITS-1){1'b1}}};
    return v[DATABITS-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// Combinational signed multiply-accumulate: c*x + acc, saturated to ACCBITS.
module fir_mac_sat
  import fir_serial_mac_pkg::*;
#(
  parameter int unsigned CBITS = 16
) (
  input  logic [CBITS-1:0]    c,
  input  logic [DATABITS-1:0] x,
  input  logic [ACCBITS-1:0]  acc,
  output logic [ACCBITS-1:0]  sum_c,
  output logic                ovf_c
);

  localparam int unsigned PBITS = DATABITS + CBITS;

  logic signed [PBITS-1:0] prod;
  logic [ACCBITS:0]        sum_wide;

  // Operands widened to the full product width so the multiply is exact.
  always_comb begin
    prod     = PBITS'($signed(c)) * PBITS'($signed(x));
    sum_wide = (ACCBITS+1)'(prod) + (ACCBITS+1)'($signed(acc));
    sum_c    = sat_acc(sum_wide);
    ovf_c    = acc_ovf(sum_wide);
  end

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed N-tap FIR: one shared MAC walks the delay line one tap per
// clock and emits a rounded, saturated sample per accepted input.
module fir_serial_mac
  import fir_serial_mac_pkg::*;
#(
  parameter int unsigned TAPS     = 5,
  parameter int unsigned CBITS    = 16,
  parameter int unsigned OUTSHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATABITS-1:0]     d_in,
  input  logic [TAPS*CBITS-1:0]   coef,
  output logic                    out_valid,
  output logic [DATABITS-1:0]     d_out,
  output logic [ACCBITS-1:0]      acc_out,
  output logic                    sat_flag
);

  localparam int unsigned IDXW = $clog2(TAPS);
  localparam logic [ACCBITS:0] RND = ((ACCBITS+1)'(1) << OUTSHIFT) >> 1;

  state_t state, state_nxt;
  logic   accept_c, mac_en_c, mac_last_c;

  logic [DATABITS-1:0] x_q [TAPS];
  logic [CBITS-1:0]    c_q [TAPS];
  logic [ACCBITS-1:0]  acc_q;
  logic [IDXW-1:0]     idx_q;

  logic [ACCBITS-1:0]  mac_sum_c;
  logic                mac_ovf_c;
  logic [ACCBITS:0]    rnd_sum_c;
  logic [ACCBITS:0]    shifted_c;

  fir_mac_sat #(.CBITS(CBITS)) u_mac (
    .c     (c_q[idx_q]),
    .x     (x_q[idx_q]),
    .acc   (acc_q),
    .sum_c (mac_sum_c),
    .ovf_c (mac_ovf_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_c   = 1'b0;
    mac_en_c   = 1'b0;
    mac_last_c = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c  = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        mac_en_c = 1'b1;
        if (idx_q == IDXW'(TAPS-1)) begin
          mac_last_c = 1'b1;
          state_nxt  = OUT;
        end
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Delay line, coefficient snapshot, accumulator and tap index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(TAPS); k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
      acc_q <= '0;
      idx_q <= '0;
    end else if (accept_c) begin
      x_q[0] <= d_in;
      for (int k = 1; k < int'(TAPS); k++) x_q[k] <= x_q[k-1];
      for (int k = 0; k < int'(TAPS); k++) c_q[k] <= coef[k*CBITS +: CBITS];
      acc_q <= '0;
      idx_q <= '0;
    end else if (mac_en_c) begin
      acc_q <= mac_sum_c;
      idx_q <= idx_q + IDXW'(1);
    end
  end

  // Round half up on the final sum so the result is registered entering OUT.
  always_comb begin
    rnd_sum_c = (ACCBITS+1)'($signed(mac_sum_c)) + RND;
    shifted_c = $signed(rnd_sum_c) >>> OUTSHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      d_out     <= '0;
      acc_out   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= mac_last_c;
      if (mac_last_c) begin
        acc_out <= mac_sum_c;
        d_out   <= sat_out(shifted_c);
      end
      if ((mac_en_c && mac_ovf_c) || (mac_last_c && out_ovf(shifted_c)))
        sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: two instances (OUTSHIFT 0 and 2) checked every
// cycle against a tap-sum reference model, plus directed scenarios.
module tb_fir_serial_mac;
  import fir_serial_mac_pkg::*;

  localparam int unsigned TAPS = 4;
  localparam int unsigned CB   = 16;
  localparam int          SH [2] = '{0, 2};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [DATABITS-1:0]  d_in = '0;
  logic [TAPS*CB-1:0]   coef = '0;

  logic                 rdy0, rdy2, ov0, ov2, sat0, sat2;
  logic [DATABITS-1:0]  dout0, dout2;
  logic [ACCBITS-1:0]   acc0, acc2;

  fir_serial_mac #(.TAPS(TAPS), .CBITS(CB), .OUTSHIFT(0)) u_fir0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .d_in(d_in),
    .coef(coef), .out_valid(ov0), .d_out(dout0), .acc_out(acc0), .sat_flag(sat0));

  fir_serial_mac #(.TAPS(TAPS), .CBITS(CB), .OUTSHIFT(2)) u_fir2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .d_in(d_in),
    .coef(coef), .out_valid(ov2), .d_out(dout2), .acc_out(acc2), .sat_flag(sat2));

  initial forever #(CLK_PERIOD/2) clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint clamp_to(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference model: m_cnt counts cycles until the filter is free again
  // (-1 right after reset, TAPS+1 right after an acceptance, 1 = output cycle).
  longint hist [TAPS];
  int     m_cnt = -1;
  longint m_acc = 0, p_acc = 0;
  longint m_d [2] = '{0, 0};
  longint p_d [2] = '{0, 0};
  bit     m_sat [2] = '{0, 0};
  bit     p_sat [2] = '{0, 0};

  initial forever begin
    longint a, c, v;
    bit     f;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      foreach (hist[k]) hist[k] = 0;
      m_cnt = -1; m_acc = 0; m_d = '{0, 0}; m_sat = '{0, 0};
    end else if (m_cnt == -1) begin
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      if (in_valid) begin
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(d_in));
        a = 0; f = 0;
        for (int k = 0; k < TAPS; k++) begin
          c = longint'($signed(coef[k*CB +: CB]));
          v = a + c * hist[k];
          a = clamp_to(v, ACCBITS);
          if (a != v) f = 1;
        end
        p_acc = a;
        for (int i = 0; i < 2; i++) begin
          v = (a + ((longint'(1) <<< SH[i]) >>> 1)) >>> SH[i];
          p_d[i]   = clamp_to(v, DATABITS);
          p_sat[i] = f || (p_d[i] != v);
        end
        m_cnt = TAPS + 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_acc = p_acc;
        m_d   = p_d;
        for (int i = 0; i < 2; i++) m_sat[i] = m_sat[i] | p_sat[i];
      end
    end
  end

  // Every cycle, both instances must match the model exactly.
  initial forever begin
    @(negedge clk);
    check("in_ready0",  longint'(rdy0), longint'(m_cnt == 0));
    check("in_ready2",  longint'(rdy2), longint'(m_cnt == 0));
    check("out_valid0", longint'(ov0),  longint'(m_cnt == 1));
    check("out_valid2", longint'(ov2),  longint'(m_cnt == 1));
    check("acc_out0",   longint'($signed(acc0)), m_acc);
    check("acc_out2",   longint'($signed(acc2)), m_acc);
    check("d_out0",     longint'($signed(dout0)), m_d[0]);
    check("d_out2",     longint'($signed(dout2)), m_d[1]);
    check("sat_flag0",  longint'(sat0), longint'(m_sat[0]));
    check("sat_flag2",  longint'(sat2), longint'(m_sat[1]));
    if (ov0) n_out++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!rdy0 && b < 50) begin
      tick(1);
      b++;
    end
    check("ready_wait", longint'(rdy0), 1);
  endtask

  task automatic set_coef(input int c0, input int c1, input int c2, input int c3);
    coef = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endtask

  // Returns in the first cycle after the acceptance edge.
  task automatic send(input logic [DATABITS-1:0] d);
    wait_idle();
    in_valid = 1'b1;
    d_in     = d;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic finish_sample();
    int lat = 1;
    while (!ov0 && lat < 20) begin
      tick(1);
      lat++;
    end
    check("latency", lat, TAPS + 1);
    wait_idle();
  endtask

  task automatic send_wait(input logic [DATABITS-1:0] d);
    send(d);
    finish_sample();
  endtask

  task automatic impulse_run(input string tag);
    int exp_imp [5] = '{1, 2, 3, 4, 0};
    set_coef(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      send_wait((i == 0) ? 16'd1 : 16'd0);
      check(tag, longint'($signed(dout0)), exp_imp[i]);
    end
  endtask

  initial begin
    int acc_at [$];
    int n0;
    #(CLK_PERIOD * 20000);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_at [$];
    int n0;

    rst_n = 1'b0;
    tick(3);
    check("rst_d_out", longint'(dout0), 0);
    check("rst_ready", longint'(rdy0), 0);
    rst_n = 1'b1;
    tick(1);

    impulse_run("impulse");

    // Handshake: in_valid held for 16 cycles.
    n0 = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d_in = 16'($urandom_range(0, 200));
      if (rdy0) acc_at.push_back(i);
      tick(1);
    end
    in_valid = 1'b0;
    wait_idle();
    check("hs_accepts", acc_at.size(), 3);
    check("hs_outputs", n_out - n0, 3);
    if (acc_at.size() >= 3) begin
      check("hs_spacing1", acc_at[1] - acc_at[0], TAPS + 2);
      check("hs_spacing2", acc_at[2] - acc_at[1], TAPS + 2);
    end

    // Saturation.
    coef = {TAPS{TEST_COEF_MAX}};
    repeat (4) send_wait(TEST_X_MAX);
    check("sat_d_out", longint'($signed(dout0)), 32767);
    check("sat_flag",  longint'(sat0), 1);
    coef = {TAPS{TEST_COEF_NEG1}};
    repeat (4) send_wait(16'd0);
    check("sat_sticky", longint'(sat0), 1);
    send_wait(TEST_X_MIN);
    check("neg_acc",   longint'($signed(acc0)), 32768);
    check("neg_d_out", longint'($signed(dout0)), 32767);

    // Rounding with OUTSHIFT=2.
    set_coef(3, 0, 0, 0);
    send_wait(16'd2);
    check("rnd_acc_p", longint'($signed(acc2)), 6);
    check("rnd_d_p",   longint'($signed(dout2)), 2);
    send_wait(-16'sd2);
    check("rnd_acc_n", longint'($signed(acc2)), -6);
    check("rnd_d_n",   longint'($signed(dout2)), -1);

    // Reset two cycles into MAC.
    set_coef(1, 2, 3, 4);
    send(16'd77);
    tick(1);
    n0 = n_out;
    rst_n = 1'b0;
    tick(8);
    check("rst_no_out", n_out - n0, 0);
    check("rst_acc",    longint'(acc0), 0);
    check("rst_sat",    longint'(sat0), 0);
    rst_n = 1'b1;
    tick(2);
    impulse_run("impulse_after_rst");

    // Coefficient change after acceptance.
    set_coef(2, 2, 2, 2);
    send(16'd100);
    coef = '0;
    finish_sample();
    check("coef_old", longint'($signed(acc0)), 200);
    send_wait(16'd50);
    check("coef_zero", longint'($signed(dout0)), 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) coef = {$urandom, $urandom};
      else if ($urandom_range(0, 1) == 0)
        set_coef($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20,
                 $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20);
      send(16'($urandom));
      if ($urandom_range(0, 2) == 0) coef = {$urandom, $urandom};
      finish_sample();
      tick($urandom_range(0, 3));
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
